// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: encoder states and default timing at a 200 MHz clock.
package ws2812_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } enc_sta_t;

  localparam int unsigned T0H_200M  = 80;
  localparam int unsigned T1H_200M  = 160;
  localparam int unsigned BIT_200M  = 250;
  // Latch/reset low time, owned by the frame controller.
  localparam int unsigned CNT_50_US = 10000;

endpackage

// File: rtl/ws2812_enc.sv
// WS2812 NRZ-PWM bit encoder with a one-entry pending slot for zero-gap chaining
// and an early bit_done strobe so the controller can queue the next bit in time.
module ws2812_enc
  import ws2812_pkg::*;
#(
  parameter int unsigned BIT_CNT   = BIT_200M,
  parameter int unsigned T0H_CNT   = T0H_200M,
  parameter int unsigned T1H_CNT   = T1H_200M,
  parameter int unsigned DONE_LEAD = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic bit_rdy_in,
  input  logic bit_data_in,
  output logic bit_done_out,
  output logic busy_out,
  output logic ovf_out,
  output logic dout_out
);

  localparam int unsigned CW = $clog2(BIT_CNT);
  localparam logic [CW-1:0] LAST    = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] DONE_AT = CW'(BIT_CNT - DONE_LEAD);
  localparam logic [CW-1:0] T0H     = CW'(T0H_CNT);
  localparam logic [CW-1:0] T1H     = CW'(T1H_CNT);

  generate
    if (!(T0H_CNT > 0 && T0H_CNT < T1H_CNT && T1H_CNT < BIT_CNT &&
          DONE_LEAD >= 2 && DONE_LEAD <= BIT_CNT - 2)) begin : g_bad_params
      $error("ws2812_enc: illegal timing parameter set");
    end
  endgenerate

  enc_sta_t      sta_q, sta_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cur_q, cur_d;
  logic          slot_vld_q, slot_vld_d;
  logic          slot_bit_q, slot_bit_d;
  logic          ovf_d, dout_d, done_d, busy_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sta_q        <= IDLE;
      cnt_q        <= '0;
      cur_q        <= 1'b0;
      slot_vld_q   <= 1'b0;
      slot_bit_q   <= 1'b0;
      ovf_out      <= 1'b0;
      dout_out     <= 1'b0;
      bit_done_out <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      sta_q        <= sta_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      slot_vld_q   <= slot_vld_d;
      slot_bit_q   <= slot_bit_d;
      ovf_out      <= ovf_d;
      dout_out     <= dout_d;
      bit_done_out <= done_d;
      busy_out     <= busy_d;
    end
  end

  always_comb begin
    sta_d      = sta_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    slot_vld_d = slot_vld_q;
    slot_bit_d = slot_bit_q;
    ovf_d      = ovf_out;
    case (sta_q)
      IDLE: begin
        if (bit_rdy_in) begin
          sta_d = SEND;
          cnt_d = '0;
          cur_d = bit_data_in;
        end
      end
      SEND: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // A strobe arriving while the slot is still full is dropped even
          // though the slot drains this cycle.
          if (slot_vld_q) begin
            cur_d      = slot_bit_q;
            slot_vld_d = 1'b0;
            if (bit_rdy_in) ovf_d = 1'b1;
          end else if (bit_rdy_in) begin
            cur_d = bit_data_in;
          end else begin
            sta_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bit_rdy_in) begin
            if (slot_vld_q) begin
              ovf_d = 1'b1;
            end else begin
              slot_vld_d = 1'b1;
              slot_bit_d = bit_data_in;
            end
          end
        end
      end
      default: sta_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next-state values.
    dout_d = (sta_d == SEND) && (cnt_d < (cur_d ? T1H : T0H));
    done_d = (sta_d == SEND) && (cnt_d == DONE_AT);
    busy_d = (sta_d == SEND) || slot_vld_d;
  end

endmodule

// File: tb/tb_ws2812_enc.sv
// Scoreboard bench for ws2812_enc: a bit-schedule model predicts pulse starts,
// high times, done strobes, busy and overflow; a monitor compares them.
module tb_ws2812_enc;
  import ws2812_pkg::*;

  localparam int BIT  = 250;
  localparam int T0H  = 80;
  localparam int T1H  = 160;
  localparam int LEAD = 4;
  localparam int NEVER = 32'h7fffffff;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic bit_rdy_in = 1'b0;
  logic bit_data_in = 1'b0;
  logic bit_done_out, busy_out, ovf_out, dout_out;

  ws2812_enc #(.BIT_CNT(BIT), .T0H_CNT(T0H), .T1H_CNT(T1H), .DONE_LEAD(LEAD)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .bit_rdy_in  (bit_rdy_in),
    .bit_data_in (bit_data_in),
    .bit_done_out(bit_done_out),
    .busy_out    (busy_out),
    .ovf_out     (ovf_out),
    .dout_out    (dout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted bit gets a start cycle; a bit is pending while its
  // start lies in the future, and a strobe seen then is dropped.
  int last_start = -100000;
  int busy_from  = 0;
  int ovf_from   = NEVER;
  int q_start[$];
  bit q_bit[$];
  int q_done[$];

  task automatic model_strobe(input int t, input bit b);
    int s;
    if (last_start > t) begin
      if (ovf_from > t + 1) ovf_from = t + 1;
    end else begin
      s = (t + 1 > last_start + BIT) ? t + 1 : last_start + BIT;
      if (t + 1 > last_start + BIT) busy_from = t + 1;
      last_start = s;
      q_start.push_back(s);
      q_bit.push_back(b);
      q_done.push_back(s + BIT - LEAD);
    end
  endtask

  task automatic model_reset();
    last_start = -100000;
    busy_from  = 0;
    ovf_from   = NEVER;
    q_start.delete();
    q_bit.delete();
    q_done.delete();
  endtask

  // Strobe is driven for the cycle following the current posedge.
  task automatic strobe(input bit b);
    bit_rdy_in  = 1'b1;
    bit_data_in = b;
    @(posedge clk_in);
    model_strobe(cyc - 1, b);
    #1 bit_rdy_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk_in);
      if (bit_done_out) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: per-cycle busy/ovf plus pulse-level waveform and done timing.
  initial begin
    int k, p_start;
    bit prev_d, p_bit;
    prev_d = 1'b0; p_bit = 1'b0; p_start = 0;
    forever begin
      @(negedge clk_in);
      k = cyc - 1;
      if (!rst_n_in) begin
        prev_d = 1'b0;
      end else begin
        chk("busy", int'(busy_out), int'(k >= busy_from && k < last_start + BIT));
        chk("ovf", int'(ovf_out), int'(k >= ovf_from));
        if (dout_out && !prev_d) begin
          if (q_start.size() == 0) begin
            chk("unexpected_rise", 1, 0);
            p_bit = 1'b0;
          end else begin
            chk("bit_start", k, q_start.pop_front());
            p_bit = q_bit.pop_front();
          end
          p_start = k;
        end else if (!dout_out && prev_d) begin
          chk("high_time", k - p_start, p_bit ? T1H : T0H);
        end
        if (bit_done_out) begin
          if (q_done.size() == 0) chk("unexpected_done", 1, 0);
          else chk("done_cycle", k, q_done.pop_front());
        end
        prev_d = dout_out;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pat;
    pat = 24'hA5C3F0;

    #1;
    chk("rst_dout", int'(dout_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_ovf", int'(ovf_out), 0);
    chk("rst_done", int'(bit_done_out), 0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    idle(3);

    // single 0, single 1
    strobe(1'b0);
    idle(300);
    strobe(1'b1);
    idle(300);

    // back-to-back frame, MSB first, strobe one cycle after each done
    strobe(pat[23]);
    for (int i = 22; i >= 0; i--) begin
      wait_done();
      strobe(pat[i]);
    end
    idle(300);

    // final-cycle bypass: second strobe lands on the last cycle of a 0-bit
    strobe(1'b0);
    idle(249);
    strobe(1'b1);
    idle(300);

    // randomized spacing and data; short gaps may overflow
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(1, 300));
      strobe(1'($urandom));
    end
    idle(600);

    // overflow: first queued, second dropped
    strobe(1'($urandom));
    idle(20);
    strobe(1'b1);
    idle(30);
    strobe(1'b0);
    idle(600);

    // reset mid 1-bit with the slot full and ovf set
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    idle(48);
    #1;
    chk("dout_before_rst", int'(dout_out), 1);
    rst_n_in = 1'b0;
    #1;
    chk("rst_async_dout", int'(dout_out), 0);
    chk("rst_async_busy", int'(busy_out), 0);
    chk("rst_async_ovf", int'(ovf_out), 0);
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    idle(10);
    strobe(1'($urandom));
    idle(600);

    chk("pulses_left", q_start.size(), 0);
    chk("dones_left", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
